// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// counter sizing helper and the divide-by-zero quotient pattern.
package seq_signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Widest operand this package supports; narrower dividers slice the constant.
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor: all ones, i.e. -1.
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT_ONES = {MAX_WIDTH{1'b1}};

  // Step counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/done request bus between a divider client and the divider.
interface seq_signed_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_signed_divider_step.sv
// One restoring division step on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, try subtracting the divisor,
// keep the difference only when it did not go negative.
module seq_signed_divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;

  // Shift, trial subtract and restore when the trial borrowed.
  always_comb begin
    shifted_s = {rem_in, q_in[WIDTH-1]};
    trial_s   = shifted_s - {2'b00, divisor_mag};
    if (trial_s[WIDTH+1]) begin
      rem_out = shifted_s[WIDTH:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial_s[WIDTH:0];
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider, C semantics: quotient truncates toward zero,
// remainder carries the dividend's sign. One restoring step per clock.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_signed_divider_if.slave bus
);

  localparam int               CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV0_QUOT = DIV0_QUOT_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_VAL  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] NEG_ONE   = {WIDTH{1'b1}};

  div_state_e       state_r;
  logic [CW-1:0]    cnt_r;
  logic             sign_q_r;
  logic             sign_rem_r;
  logic             ovf_case_r;
  logic [WIDTH-1:0] q_r;          // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs_mag_r;
  logic [WIDTH:0]   rem_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;
  logic             overflow_r;

  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   rem_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             div0_s;

  seq_signed_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_r),
    .q_in        (q_r),
    .divisor_mag (dvs_mag_r),
    .rem_out     (rem_next_s),
    .q_out       (q_next_s)
  );

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    if (bus.dividend[WIDTH-1]) begin
      dvd_mag_s = -bus.dividend;
    end else begin
      dvd_mag_s = bus.dividend;
    end
    if (bus.divisor[WIDTH-1]) begin
      dvs_mag_s = -bus.divisor;
    end else begin
      dvs_mag_s = bus.divisor;
    end
  end

  // Sign fix-up of the magnitude result. With a zero divisor no step ran, so
  // q_r still holds |dividend| and re-signing it recovers the dividend itself.
  // The -min/-1 case needs no special path: magnitude 2^(WIDTH-1) with a
  // positive sign already reads back as the most negative value.
  always_comb begin
    div0_s = (dvs_mag_r == ZERO_VAL);
    if (div0_s) begin
      quot_fix_s = DIV0_QUOT;
      rem_fix_s  = sign_rem_r ? -q_r : q_r;
    end else begin
      quot_fix_s = sign_q_r ? -q_r : q_r;
      rem_fix_s  = sign_rem_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      sign_q_r      <= 1'b0;
      sign_rem_r    <= 1'b0;
      ovf_case_r    <= 1'b0;
      q_r           <= ZERO_VAL;
      dvs_mag_r     <= ZERO_VAL;
      rem_r         <= {(WIDTH+1){1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      quotient_r    <= ZERO_VAL;
      remainder_r   <= ZERO_VAL;
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sign_q_r   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_rem_r <= bus.dividend[WIDTH-1];
            ovf_case_r <= (bus.dividend == MIN_VAL) && (bus.divisor == NEG_ONE);
            q_r        <= dvd_mag_s;
            dvs_mag_r  <= dvs_mag_s;
            rem_r      <= {(WIDTH+1){1'b0}};
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= (bus.divisor == ZERO_VAL) ? FIX : CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          if (cnt_r == LAST_STEP) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FIX: begin
          quotient_r    <= quot_fix_s;
          remainder_r   <= rem_fix_s;
          div_by_zero_r <= div0_s;
          overflow_r    <= ovf_case_r & ~div0_s;
          busy_r        <= 1'b0;
          done_r        <= 1'b1;
          state_r       <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and sweep bench for the signed divider at WIDTH=4 and WIDTH=8.
module tb_seq_signed_divider;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_signed_divider_if #(.WIDTH(4)) b4 ();
  seq_signed_divider_if #(.WIDTH(8)) b8 ();

  seq_signed_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_signed_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dz;
    int ov;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: C truncating division, plus the two special cases.
  function automatic exp_t model(input int n, input int d, input int w);
    exp_t e;
    int   mn;
    mn    = -(1 << (w - 1));
    e.n   = n;
    e.d   = d;
    e.dz  = 0;
    e.ov  = 0;
    e.lat = w + 2;
    if (d == 0) begin
      e.q = -1; e.r = n; e.dz = 1; e.lat = 2;
    end else if (n == mn && d == -1) begin
      e.q = mn; e.r = 0; e.ov = 1;
    end else begin
      e.q = n / d; e.r = n % d;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Pop the expected result for the operation just completed and compare.
  task automatic judge(input string tag, input logic done, input int lat,
                       input logic signed [31:0] q, input logic signed [31:0] r,
                       input logic dz, input logic ov, input logic busy);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " done"}, {31'd0, done}, 32'sd1);
      check({tag, " latency"}, lat, e.lat);
      check({tag, " quotient"}, q, e.q);
      check({tag, " remainder"}, r, e.r);
      check({tag, " div_by_zero"}, {31'd0, dz}, e.dz);
      check({tag, " overflow"}, {31'd0, ov}, e.ov);
      check({tag, " busy"}, {31'd0, busy}, 32'sd0);
      if (e.dz == 0 && e.ov == 0) begin
        check({tag, " q*d+r"}, q * e.d + r, e.n);
      end
    end
  endtask

  task automatic op4(input int n, input int d, input string tag);
    int lat;
    sb.push_back(model(n, d, 4));
    @(negedge clk);
    b4.start = 1'b1; b4.dividend = 4'(n); b4.divisor = 4'(d);
    @(negedge clk);
    b4.start = 1'b0; b4.dividend = 4'(n + 5); b4.divisor = 4'(d + 3);
    lat = 1;
    while (b4.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    judge(tag, b4.done, lat, $signed(b4.quotient), $signed(b4.remainder),
          b4.div_by_zero, b4.overflow, b4.busy);
  endtask

  task automatic op8(input int n, input int d, input string tag);
    int lat;
    sb.push_back(model(n, d, 8));
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'(n); b8.divisor = 8'(d);
    @(negedge clk);
    b8.start = 1'b0; b8.dividend = 8'(n + 5); b8.divisor = 8'(d + 3);
    lat = 1;
    while (b8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    judge(tag, b8.done, lat, $signed(b8.quotient), $signed(b8.remainder),
          b8.div_by_zero, b8.overflow, b8.busy);
  endtask

  task automatic check_zero4(input string tag);
    check({tag, " quotient"}, {28'd0, b4.quotient}, 32'sd0);
    check({tag, " remainder"}, {28'd0, b4.remainder}, 32'sd0);
    check({tag, " flags"}, {30'd0, b4.div_by_zero, b4.overflow}, 32'sd0);
    check({tag, " busy/done"}, {30'd0, b4.busy, b4.done}, 32'sd0);
  endtask

  // Single linear sequence of directed steps.
  initial begin
    int lat;
    int dl[8];
    dl = '{-128, -127, -3, -1, 1, 2, 7, 127};
    rst_n = 1'b0;
    b4.start = 1'b0; b4.dividend = 4'd0; b4.divisor = 4'd0;
    b8.start = 1'b0; b8.dividend = 8'd0; b8.divisor = 8'd0;
    repeat (2) @(negedge clk);
    check_zero4("reset4");
    check("reset8 outputs", {14'd0, b8.quotient, b8.remainder, b8.div_by_zero, b8.overflow},
          32'sd0);
    rst_n = 1'b1;

    op4(7, 2, "7/2");
    op4(-7, 2, "-7/2");
    op4(7, -2, "7/-2");
    op4(-7, -2, "-7/-2");
    op4(-8, -1, "-8/-1");
    op4(-8, 1, "-8/1");
    op4(-8, 3, "-8/3");
    op4(5, 0, "5/0");
    op4(6, 3, "6/3");

    // Starts during CALC and during DONE must be ignored.
    sb.push_back(model(7, 2, 4));
    @(negedge clk);
    b4.start = 1'b1; b4.dividend = 4'd7; b4.divisor = 4'd2;
    @(negedge clk);
    b4.start = 1'b0; lat = 1;
    @(negedge clk);
    lat = 2; b4.start = 1'b1; b4.dividend = 4'd3; b4.divisor = 4'd1;
    @(negedge clk);
    lat = 3; b4.start = 1'b0;
    while (b4.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    judge("ignore", b4.done, lat, $signed(b4.quotient), $signed(b4.remainder),
          b4.div_by_zero, b4.overflow, b4.busy);
    b4.start = 1'b1; b4.dividend = 4'd1; b4.divisor = 4'd1;
    @(negedge clk);
    b4.start = 1'b0;
    check("ignore done single pulse", {31'd0, b4.done}, 32'sd0);
    repeat (3) @(negedge clk);
    check("ignore no restart busy", {31'd0, b4.busy}, 32'sd0);
    check("ignore no second done", {31'd0, b4.done}, 32'sd0);
    check("ignore held quotient", $signed(b4.quotient), 32'sd3);
    check("ignore held remainder", $signed(b4.remainder), 32'sd1);

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    b4.start = 1'b1; b4.dividend = 4'd7; b4.divisor = 4'd2;
    @(negedge clk);
    b4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero4("midreset");
    repeat (3) begin
      @(negedge clk);
      check("midreset no done", {31'd0, b4.done}, 32'sd0);
    end
    rst_n = 1'b1;
    op4(3, 2, "post-reset 3/2");

    // Exhaustive WIDTH=4 sweep over nonzero divisors.
    for (int n = -8; n < 8; n++) begin
      for (int d = -8; d < 8; d++) begin
        if (d != 0) op4(n, d, "sweep4");
      end
    end

    // WIDTH=8: every dividend against boundary divisors, then random pairs.
    foreach (dl[k]) begin
      for (int n = -128; n < 128; n++) begin
        op8(n, dl[k], "sweep8");
      end
    end
    op8(-128, 0, "w8 -128/0");
    op8(77, 0, "w8 77/0");
    repeat (200) begin
      op8(int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128, "rand8");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
